avg_pool_2x2_stage: RTL
=======================

Name: avg_pool_2x2_stage

Overview:
- Streaming 2x2 average-pool compute stage for the down_sample pipeline.
- Sits between the input-stencil line buffer, which supplies four aligned window taps per input pixel, and the pooled-output buffer, which accepts a write port with wen, ctrl_vars and data.
- Tracks the input iteration position (x, y, c) and fires only when a 2x2 window is complete (x odd, y odd).
- Averages the four taps through a 2-stage pipeline and drives the pooled write with downsampled coordinates.

Parameters:
- DATA_W, 16, pixel width (unsigned).
- IMG_W, 64, input width; must be even, >=2.
- IMG_H, 64, input height; must be even, >=2.
- CHANNELS, 4, channel count; >=1.
- CTRL_W, 16, width of each ctrl_vars element.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  synchronous restart of iteration state.
- in_valid  in  1  one input pixel (and its aligned taps) presented this cycle.
- in_taps  in  4 x DATA_W  window taps: [0]=(x-1,y-1), [1]=(x,y-1), [2]=(x-1,y), [3]=(x,y).
- cur_ctrl_vars  out  4 x CTRL_W  current input position {[0]=0, [1]=c, [2]=y, [3]=x}; drives the line-buffer write ctrl_vars.
- out_wen  out  1  pooled result write strobe.
- out_ctrl_vars  out  4 x CTRL_W  {[0]=0, [1]=c, [2]=y>>1, [3]=x>>1} of the window producing out_data.
- out_data  out  1 x DATA_W  pooled value.
- frame_done  out  1  one-cycle pulse coincident with the last pooled write of a frame.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: x, y, c = 0; all pipeline valids = 0; out_wen = 0; frame_done = 0; out_data = 0; out_ctrl_vars = 0.
- Counters advance only on in_valid (flush low):
  - x increments; at IMG_W-1, x wraps to 0 and y increments.
  - At y = IMG_H-1 with x wrap, y wraps to 0 and c increments.
  - At c = CHANNELS-1 with y wrap, c wraps to 0 (frame end).
- in_valid low: counters and input sampling hold. Gaps are legal at any position.
- cur_ctrl_vars is combinational from the counters and reflects the position of the pixel being accepted this cycle.
- Fire condition: in_valid & x[0] & y[0].
- Stage 1 (registered on fire):
  - s0 = taps[0]+taps[1], s1 = taps[2]+taps[3], each DATA_W+1 bits.
  - Latches the output coordinates and the last-window flag (x=IMG_W-1, y=IMG_H-1, c=CHANNELS-1).
- Stage 2: out_data = (s0+s1)>>2 on DATA_W+2 bits, truncated (floor), no saturation needed.
- out_wen, out_ctrl_vars, out_data and frame_done are registered together.
- Latency: fire at cycle t gives out_wen=1 at t+2 for exactly one cycle.
- Pipeline has no backpressure and always advances; back-to-back fires are impossible (x odd only every other pixel).
- Outputs valid only while out_wen=1. out_data and out_ctrl_vars hold their last values otherwise.
- frame_done = out_wen of the last window; no other pulse.
- flush (takes priority over in_valid):
  - clears counters and both pipeline valid bits next edge.
  - in-flight results are dropped; out_wen=0 the cycle after flush.
  - frame_done is suppressed.
- Reset mid-frame: immediate return to reset values; next in_valid is treated as (0,0,0).
- Widths: counters are CTRL_W bits, zero-extended into ctrl_vars.

Decomposition:
- Shared package down_sample_pkg:
  - localparams DATA_W, CTRL_W, NUM_TAPS=4, NUM_CTRL=4.
  - typedef pixel_t (logic [DATA_W-1:0]).
  - typedef ctrl_vec_t (array [3:0] of logic [CTRL_W-1:0]).
  - tap index constants TAP_NW/TAP_N/TAP_W/TAP_C.
- One natural sub-module: avg_pool_iter_counter.
  - nested x/y/c counter with enable, flush and wrap flags (x_last, y_last, c_last).
  - instantiated once; reused later for output-side address generation.

Test Plan:
- Reset then one full 4x4x1 frame (IMG_W=IMG_H=4, CHANNELS=1), continuous in_valid, taps {10,20,30,40} at every fire -> exactly 4 out_wen.
  - each out_wen 2 cycles after the pixel with x odd, y odd.
  - out_data=25.
  - out_ctrl_vars[3:2] = (0,0),(1,0),(0,1),(1,1).
  - frame_done only on the 4th write.
- Rounding: taps {1,1,1,0} -> out_data=0; taps {FFFF,FFFF,FFFF,FFFF} -> FFFF (no overflow).
- Random in_valid gaps (50% duty) over a default 64x64x4 frame:
  - 4096 writes; ctrl_vars cover c 0..3, y/x 0..31 in order.
  - cur_ctrl_vars matches the reference model each accepted cycle.
  - single frame_done.
- flush asserted one cycle after a fire at (x=5,y=3,c=0):
  - no out_wen follows.
  - next in_valid sees cur_ctrl_vars = {0,0,0,0}.
- rst_n dropped asynchronously mid-frame with a result in stage 1:
  - all outputs 0 immediately.
  - no write after release; counters restart at 0.
- Two back-to-back frames (4x4x2):
  - c increments at the y wrap, then returns to 0.
  - frame_done pulses once per frame.
  - second frame addresses repeat the first.

Source files
------------

// File: rtl/down_sample_pkg.sv
// Shared definitions for the down_sample pipeline: default widths, the pixel
// and ctrl_vars vector types, and the index maps for window taps and ctrl_vars.
package down_sample_pkg;

    localparam int DATA_W   = 16;
    localparam int CTRL_W   = 16;
    localparam int NUM_TAPS = 4;
    localparam int NUM_CTRL = 4;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [NUM_CTRL-1:0][CTRL_W-1:0] ctrl_vec_t;

    // Window tap positions relative to the current pixel (x, y)
    localparam int TAP_NW = 0;  // (x-1, y-1)
    localparam int TAP_N  = 1;  // (x,   y-1)
    localparam int TAP_W  = 2;  // (x-1, y)
    localparam int TAP_C  = 3;  // (x,   y)

    // ctrl_vars element positions
    localparam int CV_ZERO = 0;
    localparam int CV_C    = 1;
    localparam int CV_Y    = 2;
    localparam int CV_X    = 3;

endpackage

// File: rtl/avg_pool_2x2_stage_if.sv
// Stream bundle between the stencil line buffer, the pooling stage and the
// pooled-output buffer write port.
interface avg_pool_2x2_stage_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 16
);
    logic                         in_valid;
    logic [3:0][DATA_W-1:0]       in_taps;
    logic [3:0][CTRL_W-1:0]       cur_ctrl_vars;
    logic                         out_wen;
    logic [3:0][CTRL_W-1:0]       out_ctrl_vars;
    logic [DATA_W-1:0]            out_data;
    logic                         frame_done;

    modport master (
        output in_valid, in_taps,
        input  cur_ctrl_vars, out_wen, out_ctrl_vars, out_data, frame_done
    );

    modport slave (
        input  in_valid, in_taps,
        output cur_ctrl_vars, out_wen, out_ctrl_vars, out_data, frame_done
    );
endinterface

// File: rtl/avg_pool_iter_counter.sv
// Nested x/y/c iteration counter. x is innermost; each level wraps into the
// next. flush overrides the enable and returns every level to zero.
module avg_pool_iter_counter
    import down_sample_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int CHANNELS = 4,
    parameter int CTRL_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    output logic [CTRL_W-1:0] x,
    output logic [CTRL_W-1:0] y,
    output logic [CTRL_W-1:0] c,
    output logic              x_last,
    output logic              y_last,
    output logic              c_last
);
    localparam logic [CTRL_W-1:0] X_MAX = CTRL_W'(IMG_W - 1);
    localparam logic [CTRL_W-1:0] Y_MAX = CTRL_W'(IMG_H - 1);
    localparam logic [CTRL_W-1:0] C_MAX = CTRL_W'(CHANNELS - 1);
    localparam logic [CTRL_W-1:0] ONE   = CTRL_W'(1);

    logic [CTRL_W-1:0] x_q, x_d, y_q, y_d, c_q, c_d;

    assign x      = x_q;
    assign y      = y_q;
    assign c      = c_q;
    assign x_last = (x_q == X_MAX);
    assign y_last = (y_q == Y_MAX);
    assign c_last = (c_q == C_MAX);

    // Next position: step x, carry into y and then c on each wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        c_d = c_q;
        if (flush) begin
            x_d = '0;
            y_d = '0;
            c_d = '0;
        end else if (en) begin
            if (x_last) begin
                x_d = '0;
                if (y_last) begin
                    y_d = '0;
                    c_d = c_last ? '0 : c_q + ONE;
                end else begin
                    y_d = y_q + ONE;
                end
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/avg_pool_2x2_stage.sv
// Streaming 2x2 average pool. Tracks the input position, fires on the pixel
// that completes a 2x2 window (x odd, y odd), forms two pair sums in stage 1
// and the floored mean in stage 2, and writes it at the halved coordinates.
module avg_pool_2x2_stage
    import down_sample_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int CHANNELS = 4,
    parameter int CTRL_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    avg_pool_2x2_stage_if.slave  bus
);
    localparam int SUM_W = DATA_W + 1;
    localparam int ACC_W = DATA_W + 2;

    // Mean of four taps given as two pair sums; the sum fits ACC_W bits, so
    // the floored quotient always fits DATA_W and never needs saturation.
    function automatic logic [DATA_W-1:0] avg_floor(input logic [SUM_W-1:0] a,
                                                    input logic [SUM_W-1:0] b);
        logic [ACC_W-1:0] acc;
        acc = {1'b0, a} + {1'b0, b};
        return acc[ACC_W-1:2];
    endfunction

    logic [CTRL_W-1:0] x, y, c;
    logic              x_last, y_last, c_last;
    logic              fire;

    avg_pool_iter_counter #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CHANNELS (CHANNELS),
        .CTRL_W   (CTRL_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bus.in_valid),
        .flush  (flush),
        .x      (x),
        .y      (y),
        .c      (c),
        .x_last (x_last),
        .y_last (y_last),
        .c_last (c_last)
    );

    assign bus.cur_ctrl_vars[CV_ZERO] = '0;
    assign bus.cur_ctrl_vars[CV_C]    = c;
    assign bus.cur_ctrl_vars[CV_Y]    = y;
    assign bus.cur_ctrl_vars[CV_X]    = x;

    assign fire = bus.in_valid & ~flush & x[0] & y[0];

    logic                         vld_p1_q, vld_p1_d;
    logic [SUM_W-1:0]             s0_p1_q, s0_p1_d, s1_p1_q, s1_p1_d;
    logic [3:0][CTRL_W-1:0]       ctrl_p1_q, ctrl_p1_d;
    logic                         last_p1_q, last_p1_d;

    logic                         vld_p2_q, vld_p2_d;
    logic                         fd_p2_q, fd_p2_d;
    logic [DATA_W-1:0]            data_p2_q, data_p2_d;
    logic [3:0][CTRL_W-1:0]       ctrl_p2_q, ctrl_p2_d;

    // ---- stage 1: pair sums and output coordinates, captured on fire ----
    always_comb begin
        vld_p1_d  = fire;
        s0_p1_d   = s0_p1_q;
        s1_p1_d   = s1_p1_q;
        ctrl_p1_d = ctrl_p1_q;
        last_p1_d = last_p1_q;
        if (fire) begin
            s0_p1_d            = {1'b0, bus.in_taps[TAP_NW]} + {1'b0, bus.in_taps[TAP_N]};
            s1_p1_d            = {1'b0, bus.in_taps[TAP_W]} + {1'b0, bus.in_taps[TAP_C]};
            ctrl_p1_d[CV_ZERO] = '0;
            ctrl_p1_d[CV_C]    = c;
            ctrl_p1_d[CV_Y]    = y >> 1;
            ctrl_p1_d[CV_X]    = x >> 1;
            last_p1_d          = x_last & y_last & c_last;
        end
    end

    // Stage 1 valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1_q <= 1'b0;
        else        vld_p1_q <= vld_p1_d;
    end

    // Stage 1 payload; only meaningful while vld_p1_q is set
    always_ff @(posedge clk) begin
        s0_p1_q   <= s0_p1_d;
        s1_p1_q   <= s1_p1_d;
        ctrl_p1_q <= ctrl_p1_d;
        last_p1_q <= last_p1_d;
    end

    // ---- stage 2: floored mean; flush drops the in-flight window ----
    always_comb begin
        vld_p2_d  = vld_p1_q & ~flush;
        fd_p2_d   = vld_p1_q & last_p1_q & ~flush;
        data_p2_d = data_p2_q;
        ctrl_p2_d = ctrl_p2_q;
        if (vld_p2_d) begin
            data_p2_d = avg_floor(s0_p1_q, s1_p1_q);
            ctrl_p2_d = ctrl_p1_q;
        end
    end

    // Output registers; data and coordinates hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            fd_p2_q   <= 1'b0;
            data_p2_q <= '0;
            ctrl_p2_q <= '0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            fd_p2_q   <= fd_p2_d;
            data_p2_q <= data_p2_d;
            ctrl_p2_q <= ctrl_p2_d;
        end
    end

    assign bus.out_wen       = vld_p2_q;
    assign bus.frame_done    = fd_p2_q;
    assign bus.out_data      = data_p2_q;
    assign bus.out_ctrl_vars = ctrl_p2_q;

endmodule
